// File: rtl/fifo_tx_serializer.sv
// FIFO-fed asynchronous serial transmitter: pops one word per frame and sends
// start bit, data LSB-first, optional parity and stop bit on tx_o.
module fifo_tx_serializer #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    output logic             fifo_rd_en_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bit_q, bit_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic               parity_q, parity_d;
    logic               rd_en_q, rd_en_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_end;
    logic               start_ok;

    assign bit_end  = (baud_q == BAUD_LAST);
    assign start_ok = enable_i && !fifo_empty_i;

    // Next state, datapath and registered-output precompute from next state.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        parity_d = parity_q;
        baud_d   = '0;
        rd_en_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        tx_d     = 1'b1;

        unique case (state_q)
            S_IDLE:   if (start_ok) state_d = S_POP;
            S_POP:    state_d = S_LOAD;
            S_LOAD: begin
                shift_d  = fifo_rdata_i;
                parity_d = (^fifo_rdata_i) ^ PARITY_ODD;
                bit_d    = '0;
                state_d  = S_START;
            end
            S_START:  if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + CNT_W'(1);
                    if (bit_q == BIT_LAST) state_d = PARITY_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP:   if (bit_end) state_d = start_ok ? S_POP : S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Baud counter restarts on every state change and at each bit boundary.
        if (state_d != state_q || bit_end) begin
            baud_d = '0;
        end else if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
            baud_d = baud_q + BAUD_W'(1);
        end

        rd_en_d = (state_d == S_POP);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_STOP) && (baud_d == BAUD_LAST);

        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            baud_q   <= '0;
            parity_q <= 1'b0;
            rd_en_q  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            parity_q <= parity_d;
            rd_en_q  <= rd_en_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign fifo_rd_en_o = rd_en_q;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed bench for fifo_tx_serializer: three instances (no parity, even, odd)
// fed by small registered-read FIFO models, with a bit-level serial receiver.
module tb_fifo_tx_serializer;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] en;
    logic [2:0] empty;
    logic [2:0] rd;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] done;
    logic [7:0] rdata [3];
    logic [7:0] mem [3][64];
    int         wr_ptr [3] = '{0, 0, 0};
    int         rd_ptr [3] = '{0, 0, 0};
    int         pops   [3] = '{0, 0, 0};
    int         dones  [3] = '{0, 0, 0};
    int         rd_err [3] = '{0, 0, 0};
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    fifo_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en[0]), .fifo_empty_i(empty[0]),
        .fifo_rdata_i(rdata[0]), .fifo_rd_en_o(rd[0]), .tx_o(tx[0]), .busy_o(busy[0]),
        .frame_done_o(done[0]));

    fifo_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en[1]), .fifo_empty_i(empty[1]),
        .fifo_rdata_i(rdata[1]), .fifo_rd_en_o(rd[1]), .tx_o(tx[1]), .busy_o(busy[1]),
        .frame_done_o(done[1]));

    fifo_tx_serializer #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut2 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en[2]), .fifo_empty_i(empty[2]),
        .fifo_rdata_i(rdata[2]), .fifo_rd_en_o(rd[2]), .tx_o(tx[2]), .busy_o(busy[2]),
        .frame_done_o(done[2]));

    assign empty[0] = (wr_ptr[0] == rd_ptr[0]);
    assign empty[1] = (wr_ptr[1] == rd_ptr[1]);
    assign empty[2] = (wr_ptr[2] == rd_ptr[2]);

    // FIFO read port model: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd[i]) begin
                if (empty[i]) rd_err[i] <= rd_err[i] + 1;
                rdata[i]  <= mem[i][rd_ptr[i] % 64];
                rd_ptr[i] <= rd_ptr[i] + 1;
                pops[i]   <= pops[i] + 1;
            end
            if (done[i]) dones[i] <= dones[i] + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int w, input logic [7:0] d);
        mem[w][wr_ptr[w] % 64] = d;
        wr_ptr[w] = wr_ptr[w] + 1;
    endtask

    // Receive one frame: counts idle-high cycles before the start bit, samples
    // mid-bit, and ends on the last stop-bit cycle where frame_done must be high.
    task automatic rx_frame(input int w, input int nb, output logic [8:0] bits, output int gap);
        int t;
        bits = '0;
        gap  = 0;
        t    = 0;
        step();
        while (tx[w] === 1'b1 && t < 300) begin
            gap++;
            t++;
            step();
        end
        check("rx_start_fall", 32'(tx[w]), 32'(0));
        if (tx[w] !== 1'b0) return;
        step();
        step();
        check("rx_start_bit", 32'(tx[w]), 32'(0));
        for (int b = 0; b < nb; b++) begin
            repeat (4) step();
            bits[b] = tx[w];
        end
        repeat (4) step();
        check("rx_stop_bit", 32'(tx[w]), 32'(1));
        step();
        check("rx_frame_done", 32'(done[w]), 32'(1));
    endtask

    initial begin
        logic [9:0] f_a5;
        logic [7:0] b2b [16];
        logic [8:0] bits;
        int         gap;
        int         p0;
        int         d0;

        f_a5 = 10'b1_10100101_0;
        b2b  = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hC3,
                 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

        // Reset held with a non-empty FIFO and enable high.
        rst_n = 1'b0;
        en    = 3'b001;
        push(0, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_tx", 32'(tx[0]), 32'(1));
            check("rst_rd_en", 32'(rd[0]), 32'(0));
            check("rst_busy", 32'(busy[0]), 32'(0));
        end

        // Single frame of 0xA5: pop at N+1, start bit at N+3, 40-cycle frame.
        rst_n = 1'b1;
        step();
        check("sf_pop", 32'(rd[0]), 32'(1));
        check("sf_busy_pop", 32'(busy[0]), 32'(1));
        check("sf_tx_pop", 32'(tx[0]), 32'(1));
        step();
        check("sf_pop_once", 32'(rd[0]), 32'(0));
        check("sf_tx_load", 32'(tx[0]), 32'(1));
        for (int k = 0; k < 40; k++) begin
            step();
            check("sf_tx_bit", 32'(tx[0]), 32'(f_a5[k / 4]));
            check("sf_done", 32'(done[0]), 32'(k == 39));
            check("sf_busy", 32'(busy[0]), 32'(1));
            check("sf_rd_en", 32'(rd[0]), 32'(0));
        end
        step();
        check("sf_busy_end", 32'(busy[0]), 32'(0));
        check("sf_tx_idle", 32'(tx[0]), 32'(1));
        check("sf_empty", 32'(empty[0]), 32'(1));
        check("sf_pops", 32'(pops[0]), 32'(1));
        check("sf_dones", 32'(dones[0]), 32'(1));

        // Back-to-back: 16 queued words, 2-cycle high gap between frames.
        p0 = pops[0];
        d0 = dones[0];
        for (int i = 0; i < 16; i++) push(0, b2b[i]);
        for (int i = 0; i < 16; i++) begin
            rx_frame(0, 8, bits, gap);
            check("b2b_data", 32'(bits[7:0]), 32'(b2b[i]));
            check("b2b_gap", 32'(gap), 32'(2));
        end
        repeat (5) step();
        check("b2b_pops", 32'(pops[0] - p0), 32'(16));
        check("b2b_dones", 32'(dones[0] - d0), 32'(16));
        check("b2b_busy_end", 32'(busy[0]), 32'(0));

        // Even parity: A5 -> 0, 03 -> 0, 01 -> 1; 44-cycle frames.
        push(1, 8'hA5);
        push(1, 8'h03);
        push(1, 8'h01);
        en[1] = 1'b1;
        rx_frame(1, 9, bits, gap);
        check("par_even_a5_data", 32'(bits[7:0]), 32'(8'hA5));
        check("par_even_a5_bit", 32'(bits[8]), 32'(0));
        rx_frame(1, 9, bits, gap);
        check("par_even_03_data", 32'(bits[7:0]), 32'(8'h03));
        check("par_even_03_bit", 32'(bits[8]), 32'(0));
        rx_frame(1, 9, bits, gap);
        check("par_even_01_data", 32'(bits[7:0]), 32'(8'h01));
        check("par_even_01_bit", 32'(bits[8]), 32'(1));
        en[1] = 1'b0;

        // Odd parity: 07 -> 0.
        push(2, 8'h07);
        en[2] = 1'b1;
        rx_frame(2, 9, bits, gap);
        check("par_odd_07_data", 32'(bits[7:0]), 32'(8'h07));
        check("par_odd_07_bit", 32'(bits[8]), 32'(0));
        en[2] = 1'b0;

        // Enable dropped during DATA of the first of three frames.
        en[0] = 1'b0;
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        repeat (3) step();
        check("gate_no_pop_disabled", 32'(busy[0]), 32'(0));
        p0 = pops[0];
        d0 = dones[0];
        en[0] = 1'b1;
        repeat (10) step();
        check("gate_in_frame", 32'(busy[0]), 32'(1));
        en[0] = 1'b0;
        repeat (60) step();
        check("gate_pops", 32'(pops[0] - p0), 32'(1));
        check("gate_dones", 32'(dones[0] - d0), 32'(1));
        check("gate_busy", 32'(busy[0]), 32'(0));
        check("gate_tx", 32'(tx[0]), 32'(1));
        en[0] = 1'b1;
        rx_frame(0, 8, bits, gap);
        check("gate_word2", 32'(bits[7:0]), 32'(8'h22));
        rx_frame(0, 8, bits, gap);
        check("gate_word3", 32'(bits[7:0]), 32'(8'h33));
        check("gate_pops_total", 32'(pops[0] - p0), 32'(3));

        // Reset during DATA aborts the frame asynchronously.
        p0 = pops[0];
        push(0, 8'h5A);
        push(0, 8'hC3);
        repeat (12) step();
        check("mrst_pre_busy", 32'(busy[0]), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mrst_tx", 32'(tx[0]), 32'(1));
        check("mrst_busy", 32'(busy[0]), 32'(0));
        check("mrst_rd_en", 32'(rd[0]), 32'(0));
        step();
        step();
        rst_n = 1'b1;
        rx_frame(0, 8, bits, gap);
        check("mrst_next_word", 32'(bits[7:0]), 32'(8'hC3));
        check("mrst_pops", 32'(pops[0] - p0), 32'(2));

        check("rd_error_0", 32'(rd_err[0]), 32'(0));
        check("rd_error_1", 32'(rd_err[1]), 32'(0));
        check("rd_error_2", 32'(rd_err[2]), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_tx_serializer.md
Name: fifo_tx_serializer

Overview:
- Downstream consumer of the synchronous FIFO (DEPTH 16, WIDTH 8). Pops one word at a time whenever the FIFO is non-empty and transmission is enabled.
- Shifts each word out on a single serial line as an asynchronous frame: start bit, data LSB-first, optional parity, stop bit.
- Sits between the FIFO read port and the chip-level serial TX pin.

Parameters:
- WIDTH, 8: data word width; must equal the FIFO WIDTH.
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range >= 2.
- PARITY_EN, 0: 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_i  input  1  asynchronous reset, active-low.
- enable_i  input  1  1 = allowed to start new frames.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_rdata_i  input  WIDTH  FIFO read data; valid in the cycle after fifo_rd_en_o is high (registered FIFO read).
- fifo_rd_en_o  output  1  FIFO pop strobe; one-cycle pulse per word.
- tx_o  output  1  serial line; idle high.
- busy_o  output  1  1 from the POP state through the end of the stop bit.
- frame_done_o  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset (rst_i = 0, asynchronous):
  - state = IDLE.
  - Outputs: tx_o = 1, fifo_rd_en_o = 0, busy_o = 0, frame_done_o = 0.
  - Shift register, bit counter and baud counter = 0.
  - Reset mid-frame aborts the frame immediately; tx_o returns high.
- FSM states: IDLE, POP, LOAD, START, DATA, PARITY, STOP. All outputs are registered.
  - IDLE: if enable_i && !fifo_empty_i, go to POP; otherwise stay in IDLE.
  - POP: fifo_rd_en_o = 1 for exactly this one cycle. Next state: LOAD.
  - LOAD: capture fifo_rdata_i into the shift register and compute parity over the full word. tx_o goes to 0 at the edge that ends LOAD. Next state: START.
  - START: tx_o = 0 for CLKS_PER_BIT cycles. Next state: DATA.
  - DATA: tx_o = shift_reg[0]; shift right every CLKS_PER_BIT cycles. After WIDTH bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx_o = parity bit for CLKS_PER_BIT cycles.
    - Even: XOR of the data bits.
    - Odd: the inverse of that.
  - STOP: tx_o = 1 for CLKS_PER_BIT cycles; frame_done_o is pulsed in the final cycle. Next state: POP if enable_i && !fifo_empty_i, else IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change. Width = clog2(CLKS_PER_BIT).
- Latency: if the FIFO becomes non-empty while in IDLE at cycle N, fifo_rd_en_o is high at N+1 and tx_o falls at N+3.
- Frame length: (1 + WIDTH + PARITY_EN + 1) x CLKS_PER_BIT cycles.
- Inter-frame gap on back-to-back frames: exactly 2 cycles of tx_o = 1 (POP, LOAD) after the stop bit.
- Empty FIFO: fifo_rd_en_o is never asserted while fifo_empty_i = 1, so the block never causes an rd_error on the FIFO.
- enable_i deasserted mid-frame: the current frame completes in full; no new POP is issued.
- fifo_empty_i is sampled only in IDLE and in the final cycle of STOP; changes at other times are ignored.
- Data sampled in LOAD is held stable regardless of later FIFO writes.

Test Plan:
- Reset: hold rst_i = 0 with the FIFO non-empty and enable_i = 1 -> tx_o = 1, fifo_rd_en_o = 0, busy_o = 0 throughout.
- Single frame (CLKS_PER_BIT = 4, PARITY_EN = 0): FIFO holds 0xA5.
  - fifo_rd_en_o pulses once.
  - tx_o sequence, 4 cycles per bit: 0 | 1,0,1,0,0,1,0,1 | 1.
  - frame_done_o pulses once at cycle 40 after tx_o falls.
  - busy_o returns low; the FIFO reports empty.
- Back-to-back (16 words written by the FIFO bench, enable_i = 1):
  - Exactly 16 fifo_rd_en_o pulses and 16 frame_done_o pulses.
  - Received bytes match the written sequence in order.
  - 2-cycle high gap between frames; FIFO rd_error_o never asserts.
- Parity (PARITY_EN = 1, CLKS_PER_BIT = 4):
  - 0xA5, even parity -> parity bit 0; frame is 44 cycles.
  - 0x07, odd parity -> parity bit 0.
  - 0x03, even parity -> parity bit 0; 0x01, even parity -> parity bit 1.
- Enable gating: drop enable_i during the DATA state of frame 1 with 3 words queued -> frame 1 completes, no further pops. Re-enable -> the remaining 2 words are sent.
- Reset mid-frame: assert rst_i = 0 during the DATA state -> tx_o = 1 asynchronously and busy_o = 0. After release, the next queued word is transmitted from its start bit.
